// File: rtl/fixed_mul_pipe.sv
// Pipelined signed fixed-point multiplier: (a*b)/2^FRAC with per-sample truncate/round mode,
// output saturation and a sideband tag, under a valid/ready handshake with global stall.
module fixed_mul_pipe #(
    parameter int W     = 16,
    parameter int FRAC  = 16,
    parameter int LAT   = 2,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_round,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_sat,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = 2 * W;
    localparam int HS = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW:0] HALF = (FRAC > 0) ? ((PW + 1)'(1) << HS) : '0;
    localparam logic signed [PW+1:0] Q_MAX = $signed({{(W + 3){1'b0}}, {(W - 1){1'b1}}});
    localparam logic signed [PW+1:0] Q_MIN = $signed({{(W + 3){1'b1}}, {(W - 1){1'b0}}});
    localparam logic [W-1:0] D_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] D_MIN = {1'b1, {(W - 1){1'b0}}};

    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_sat_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [W-1:0]     out_data_d;
    logic             out_sat_d;

    logic             stall;
    logic signed [PW-1:0] a_ext, b_ext, prod_c;
    logic signed [PW-1:0] fin_p;
    logic             fin_rnd, fin_vld;
    logic [TAG_W-1:0] fin_tag;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    assign a_ext  = {{W{in_a[W-1]}}, in_a};
    assign b_ext  = {{W{in_b[W-1]}}, in_b};
    assign prod_c = a_ext * b_ext;

    // Full-width product travels through LAT-1 stages; the last register applies round/saturate.
    for (genvar gi = 0; gi < LAT - 1; gi++) begin : g_stage
        logic signed [PW-1:0] p_q, p_d;
        logic                 rnd_q, rnd_d, vld_q, vld_d;
        logic [TAG_W-1:0]     tag_q, tag_d;

        if (gi == 0) begin : g_first
            assign p_d   = prod_c;
            assign rnd_d = in_round;
            assign vld_d = in_valid;
            assign tag_d = in_tag;
        end else begin : g_next
            assign p_d   = g_stage[gi-1].p_q;
            assign rnd_d = g_stage[gi-1].rnd_q;
            assign vld_d = g_stage[gi-1].vld_q;
            assign tag_d = g_stage[gi-1].tag_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_q   <= '0;
                rnd_q <= 1'b0;
                vld_q <= 1'b0;
                tag_q <= '0;
            end else if (!stall) begin
                p_q   <= p_d;
                rnd_q <= rnd_d;
                vld_q <= vld_d;
                tag_q <= tag_d;
            end
        end
    end

    if (LAT == 1) begin : g_direct
        assign fin_p   = prod_c;
        assign fin_rnd = in_round;
        assign fin_vld = in_valid;
        assign fin_tag = in_tag;
    end else begin : g_piped
        assign fin_p   = g_stage[LAT-2].p_q;
        assign fin_rnd = g_stage[LAT-2].rnd_q;
        assign fin_vld = g_stage[LAT-2].vld_q;
        assign fin_tag = g_stage[LAT-2].tag_q;
    end

    // Work on the magnitude so both modes are symmetric about zero.
    logic signed [PW:0]   p_ext;
    logic [PW:0]          mag, mag_r;
    logic signed [PW+1:0] q;

    always_comb begin
        p_ext = {fin_p[PW-1], fin_p};
        mag   = fin_p[PW-1] ? -p_ext : p_ext;
        mag_r = (mag + (fin_rnd ? HALF : '0)) >> FRAC;
        q     = fin_p[PW-1] ? -$signed({1'b0, mag_r}) : $signed({1'b0, mag_r});
        out_data_d = q[W-1:0];
        out_sat_d  = 1'b0;
        if (q > Q_MAX) begin
            out_data_d = D_MAX;
            out_sat_d  = 1'b1;
        end else if (q < Q_MIN) begin
            out_data_d = D_MIN;
            out_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_tag_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= fin_vld;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_tag_q   <= fin_tag;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Bench for fixed_mul_pipe: three configurations fed in lockstep, scoreboard queues per instance.
module tb_fixed_mul_pipe;

    typedef struct {
        longint d;
        longint s;
        longint t;
        longint acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_round, out_ready;
    logic [15:0] in_a, in_b;
    logic [1:0]  in_tag;

    logic        rdy0, ov0, os0;
    logic [15:0] od0;
    logic [1:0]  ot0;
    logic        rdy1, ov1, os1;
    logic [15:0] od1;
    logic [1:0]  ot1;
    logic        rdy2, ov2, os2;
    logic [7:0]  od2;
    logic [1:0]  ot2;
    logic        v_g;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_lat = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Secondary instances accept exactly when the main instance does.
    assign v_g = in_valid & rdy0;

    fixed_mul_pipe #(.W(16), .FRAC(16), .LAT(3), .TAG_W(2)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_round(in_round), .in_tag(in_tag),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0), .out_tag(ot0));

    fixed_mul_pipe #(.W(16), .FRAC(15), .LAT(2), .TAG_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(v_g), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_round(in_round), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .out_sat(os1), .out_tag(ot1));

    fixed_mul_pipe #(.W(8), .FRAC(0), .LAT(1), .TAG_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(v_g), .in_ready(rdy2),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_round(in_round), .in_tag(in_tag),
        .out_valid(ov2), .out_ready(1'b1), .out_data(od2), .out_sat(os2), .out_tag(ot2));

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input longint a, input longint b, input int w, input int frac,
                                  input bit r, output longint d, output longint s);
        longint p, q, m, mx, mn;
        p = a * b;
        if (frac == 0) q = p;
        else if (!r) q = p / (longint'(1) <<< frac);
        else begin
            m = (p < 0) ? -p : p;
            q = (m + (longint'(1) <<< (frac - 1))) / (longint'(1) <<< frac);
            if (p < 0) q = -q;
        end
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        d = q;
        s = 0;
        if (q > mx) begin d = mx; s = 1; end
        else if (q < mn) begin d = mn; s = 1; end
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int a, input int b, input bit r, input int t);
        exp_t e;
        longint d, s;
        int n;
        in_a = a[15:0]; in_b = b[15:0]; in_round = r; in_tag = t[1:0]; in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!rdy0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("accept_timeout", longint'(rdy0), 1);
        e.t = longint'(t[1:0]);
        e.acc = longint'(cyc + 1);
        model(longint'($signed(a[15:0])), longint'($signed(b[15:0])), 16, 16, r, d, s);
        e.d = d; e.s = s; q0.push_back(e);
        model(longint'($signed(a[15:0])), longint'($signed(b[15:0])), 16, 15, r, d, s);
        e.d = d; e.s = s; q1.push_back(e);
        model(longint'($signed(a[7:0])), longint'($signed(b[7:0])), 8, 0, r, d, s);
        e.d = d; e.s = s; q2.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Replace the newest model expectation with a hand-derived constant.
    task automatic k0(input longint d, input longint s);
        exp_t e;
        e = q0[q0.size()-1]; e.d = d; e.s = s; q0[q0.size()-1] = e;
    endtask
    task automatic k1(input longint d, input longint s);
        exp_t e;
        e = q1[q1.size()-1]; e.d = d; e.s = s; q1[q1.size()-1] = e;
    endtask
    task automatic k2(input longint d, input longint s);
        exp_t e;
        e = q2[q2.size()-1]; e.d = d; e.s = s; q2[q2.size()-1] = e;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("drain_timeout", longint'(q0.size() + q1.size() + q2.size()), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ov0 && out_ready) begin
                check("q0_avail", longint'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("data0", longint'($signed(od0)), e.d);
                    check("sat0", longint'(os0), e.s);
                    check("tag0", longint'(ot0), e.t);
                    if (chk_lat) check("lat0", longint'(cyc) - e.acc, 2);
                end
            end
            if (ov1) begin
                check("q1_avail", longint'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("data1", longint'($signed(od1)), e.d);
                    check("sat1", longint'(os1), e.s);
                    check("tag1", longint'(ot1), e.t);
                end
            end
            if (ov2) begin
                check("q2_avail", longint'(q2.size() > 0), 1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    check("data2", longint'($signed(od2)), e.d);
                    check("sat2", longint'(os2), e.s);
                    check("tag2", longint'(ot2), e.t);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_a = 16'h7fff; in_b = 16'h7fff;
        in_round = 1'b1; in_tag = 2'd3; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid0", longint'(ov0), 0);
        check("rst_data0", longint'(od0), 0);
        check("rst_sat0", longint'(os0), 0);
        check("rst_tag0", longint'(ot0), 0);
        check("rst_ready0", longint'(rdy0), 1);
        check("rst_valid1", longint'(ov1), 0);
        check("rst_valid2", longint'(ov2), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(-3, 5, 0, 0);            k0(0, 0);
        send(-32768, -32768, 0, 1);   k0(16384, 0); k1(32767, 1);
        send(256, 128, 0, 2);         k0(0, 0);
        send(256, 128, 1, 3);         k0(1, 0);
        send(-256, 128, 0, 0);        k0(0, 0);
        send(-256, 128, 1, 1);        k0(-1, 0);
        send(255, 128, 0, 2);         k0(0, 0);
        send(255, 128, 1, 3);         k0(0, 0);
        send(-32768, 32767, 0, 0);    k1(-32767, 0);
        send(100, 100, 0, 1);         k2(127, 1);
        drain();

        for (int a = -32767; a <= 32767; a += 2731)
            for (int b = -32767; b <= 32767; b += 2731)
                send(a, b, 0, (a + b) & 3);
        repeat (150)
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        drain();

        chk_lat = 1'b1;
        for (int t = 0; t < 4; t++) send(1000 * (t + 1), 3000, 0, t);
        drain();
        chk_lat = 1'b0;

        fork
            begin
                for (int i = 0; i < 6; i++) send((i + 1) * 1111, -(i + 2) * 777, i[0], i & 3);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                #1 check("in_ready_fall", longint'(rdy0), 0);
                repeat (4) begin
                    @(negedge clk);
                    check("hold_valid", longint'(ov0), 1);
                    if (q0.size() > 0) begin
                        check("hold_data", longint'($signed(od0)), q0[0].d);
                        check("hold_tag", longint'(ot0), q0[0].t);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(5000, 6000, 0, 2);
        send(7000, -8000, 1, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        #1;
        check("arst_valid", longint'(ov0), 0);
        check("arst_data", longint'(od0), 0);
        check("arst_sat", longint'(os0), 0);
        check("arst_tag", longint'(ot0), 0);
        check("arst_ready", longint'(rdy0), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(2, 16384, 1, 1);         k0(1, 0);
        drain();
        repeat (5) @(negedge clk);
        check("no_stale", longint'(ov0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
